// File: rtl/captura_operando.sv
`default_nettype none
// ============================================================================
// captura_operando: turns scanner key presses into single key events, builds
// a packed-BCD operand and offers {operand, operator} over valid/ready.
// Optional debounce filter: define ANTIREBOTE_EN.      Rev 1.0
// ============================================================================
module captura_operando #(
   parameter int DIGITOS         = 4,
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         button_pressed,
   input  logic [4:0]                   indice_boton,
   input  logic                         consumidor_listo,
   output logic [4*DIGITOS-1:0]         operando,
   output logic [$clog2(DIGITOS+1)-1:0] num_digitos,
   output logic [2:0]                   operador,
   output logic                         operando_valido,
   output logic                         tecla_evento,
   output logic [4:0]                   tecla_codigo,
   output logic                         desborde
);

   localparam int NW = $clog2(DIGITOS+1);
   localparam int OW = 4*DIGITOS;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      ESTABLE = 2'd1,
      SOLTAR  = 2'd2
   } estado_t;

   estado_t        estado_q, estado_d;
   logic           btn_q;
   logic [4:0]     idx_q;
   logic           evento;
   logic [4:0]     w_key;

   logic [OW-1:0]  operando_q, operando_d;
   logic [NW-1:0]  num_q, num_d;
   logic [2:0]     operador_q, operador_d;
   logic           valido_q, valido_d;
   logic           desborde_q, desborde_d;
   logic [4:0]     codigo_q, codigo_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q <= 1'b0;
         idx_q <= '0;
      end else begin
         btn_q <= button_pressed;
         idx_q <= indice_boton;
      end
   end

`ifdef ANTIREBOTE_EN
   localparam int CW = $clog2(DEBOUNCE_CICLOS+1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    key_q, key_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= ESPERA;
         cnt_q    <= '0;
         key_q    <= '0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
      end
   end

   // Counter holds the number of consecutive stable samples seen so far.
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      evento   = 1'b0;
      if (!enable) begin
         estado_d = ESPERA;
         cnt_d    = '0;
      end else begin
         case (estado_q)
            ESPERA: if (btn_q) begin
               estado_d = ESTABLE;
               key_d    = idx_q;
               cnt_d    = CW'(1);
            end
            ESTABLE: if (cnt_q == CW'(DEBOUNCE_CICLOS)) begin
               estado_d = SOLTAR;
               cnt_d    = '0;
               evento   = !key_q[4];
            end else if (!btn_q || idx_q != key_q) begin
               estado_d = ESPERA;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            SOLTAR: if (!btn_q) estado_d = ESPERA;
            default: estado_d = ESPERA;
         endcase
      end
   end

   assign w_key = key_q;
`else
   always_ff @(posedge clk) begin
      if (reset) estado_q <= ESPERA;
      else       estado_q <= estado_d;
   end

   always_comb begin
      estado_d = estado_q;
      evento   = 1'b0;
      if (!enable) begin
         estado_d = ESPERA;
      end else begin
         case (estado_q)
            ESPERA: if (btn_q) begin
               estado_d = SOLTAR;
               evento   = !idx_q[4];
            end
            SOLTAR: if (!btn_q) estado_d = ESPERA;
            default: estado_d = ESPERA;
         endcase
      end
   end

   assign w_key = idx_q;
`endif

   // Clear (key 15) and a completed hand-off share the same net effect.
   always_comb begin
      operando_d = operando_q;
      num_d      = num_q;
      operador_d = operador_q;
      valido_d   = valido_q;
      desborde_d = desborde_q;
      codigo_d   = evento ? w_key : codigo_q;
      if ((evento && w_key == 5'd15) || (valido_q && consumidor_listo)) begin
         operando_d = '0;
         num_d      = '0;
         operador_d = '0;
         valido_d   = 1'b0;
         desborde_d = 1'b0;
      end else if (evento && !valido_q) begin
         if (w_key < 5'd10) begin
            if (num_q < NW'(DIGITOS)) begin
               operando_d = (operando_q << 4) | OW'(w_key[3:0]);
               num_d      = num_q + 1'b1;
            end else begin
               desborde_d = 1'b1;
            end
         end else begin
            operador_d = 3'(w_key - 5'd9);
            valido_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         operando_q <= '0;
         num_q      <= '0;
         operador_q <= '0;
         valido_q   <= 1'b0;
         desborde_q <= 1'b0;
         codigo_q   <= '0;
      end else begin
         operando_q <= operando_d;
         num_q      <= num_d;
         operador_q <= operador_d;
         valido_q   <= valido_d;
         desborde_q <= desborde_d;
         codigo_q   <= codigo_d;
      end
   end

   assign operando        = operando_q;
   assign num_digitos     = num_q;
   assign operador        = operador_q;
   assign operando_valido = valido_q;
   assign tecla_evento    = evento;
   assign tecla_codigo    = codigo_q;
   assign desborde        = desborde_q;

endmodule
`default_nettype wire
